audio_sched: RTL

Sample scheduler for the PCM audio output path. Arbitrates two 16-bit sample sources (ch0: microphone/PCM loopback, ch1: game sound effects) via valid/ready handshakes, buffers one sample per channel, selects or saturating-mixes them per `mode`, and feeds the serializer's `d_in`/`enable`, advancing one sample per serializer frame on its `done` pulse. Sits between the game/mic logic and the `audio` serializer, sharing `clk` and `reset`.

---
 rtl/audio_sched_pkg.sv | 52 +++++
 rtl/audio_sched_hold.sv | 57 +++++
 rtl/audio_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/audio_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// audio_sched_pkg : shared types, mode encodings and mix helpers
// Revision 1.0
// ----------------------------------------------------------------------
package audio_sched_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_MUTE = 2'b00;
  localparam logic [1:0] MODE_CH0  = 2'b01;
  localparam logic [1:0] MODE_CH1  = 2'b10;
  localparam logic [1:0] MODE_MIX  = 2'b11;

  localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

  // Bit N set when channel N participates in the given mode.
  function automatic logic [1:0] sel_mask(input logic [1:0] mode);
    sel_mask = {(mode == MODE_CH1) || (mode == MODE_MIX),
                (mode == MODE_CH0) || (mode == MODE_MIX)};
  endfunction

  function automatic logic [SAMPLE_W-1:0] sat_add(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b);
    logic [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
      sat_add = sum[SAMPLE_W] ? SAT_MIN : SAT_MAX;
    else
      sat_add = sum[SAMPLE_W-1:0];
  endfunction

  function automatic logic [SAMPLE_W-1:0] pick_sample(input logic [1:0]          mode,
                                                      input logic [SAMPLE_W-1:0] a,
                                                      input logic [SAMPLE_W-1:0] b);
    case (mode)
      MODE_CH0: pick_sample = a;
      MODE_CH1: pick_sample = b;
      MODE_MIX: pick_sample = sat_add(a, b);
      default:  pick_sample = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sched_hold.sv
`default_nettype none
// ----------------------------------------------------------------------
// aud_hold : one-entry sample holding register with valid/ready intake
// Revision 1.0
// ----------------------------------------------------------------------
module aud_hold #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              consume_i,
  input  logic              flush_i,
  input  logic              en_nxt_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic              ready_q;
  logic [DATA_W-1:0] data_q;
  logic              w_xfer;

  assign w_xfer = valid_i & ready_q;

  // Flush beats everything so a stopped or deselected channel always ends empty.
  always_comb begin
    full_d = full_q;
    if (flush_i)
      full_d = 1'b0;
    else if (w_xfer)
      full_d = 1'b1;
    else if (consume_i)
      full_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= en_nxt_i & ~full_d;
      if (w_xfer)
        data_q <= data_i;
    end
  end

  assign ready_o = ready_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/audio_sched.sv
`default_nettype none
// ----------------------------------------------------------------------
// audio_sched : two-source PCM sample scheduler feeding the serializer
// Revision 1.0
// ----------------------------------------------------------------------
module audio_sched
  import audio_sched_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int UCNT_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic [1:0]        mode_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  input  logic              done_i,
  output logic [DATA_W-1:0] d_in_o,
  output logic              enable_o,
  output logic              underrun_o,
  output logic [UCNT_W-1:0] underrun_cnt_o
);

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              done_q;
  logic [DATA_W-1:0] d_in_q, d_in_d;
  logic              enable_q, enable_d;
  logic              underrun_q, underrun_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;

  logic [1:0]        w_full, w_consume, w_flush, w_en_nxt;
  logic [1:0]        w_sel_q, w_sel_new, w_missing;
  logic [DATA_W-1:0] w_hold0, w_hold1, w_smp0, w_smp1;
  logic              w_done_rise, w_all_full;

  assign w_done_rise = done_i & ~done_q;
  assign w_sel_q     = sel_mask(mode_q);
  assign w_sel_new   = sel_mask(mode_i);
  assign w_all_full  = &(w_full | ~w_sel_q);
  assign w_missing   = w_sel_new & ~w_full;
  // An empty channel contributes silence to the frame.
  assign w_smp0      = w_full[0] ? w_hold0 : '0;
  assign w_smp1      = w_full[1] ? w_hold1 : '0;
  assign w_en_nxt    = (state_d == ST_OFF) ? 2'b00 : sel_mask(mode_d);

  aud_hold #(.DATA_W(DATA_W)) u_hold0 (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .valid_i   (req0_valid_i),
    .data_i    (req0_data_i),
    .ready_o   (req0_ready_o),
    .consume_i (w_consume[0]),
    .flush_i   (w_flush[0]),
    .en_nxt_i  (w_en_nxt[0]),
    .full_o    (w_full[0]),
    .data_o    (w_hold0)
  );

  aud_hold #(.DATA_W(DATA_W)) u_hold1 (
    .clk_i     (clk_i),
    .rst_i     (reset_i),
    .valid_i   (req1_valid_i),
    .data_i    (req1_data_i),
    .ready_o   (req1_ready_o),
    .consume_i (w_consume[1]),
    .flush_i   (w_flush[1]),
    .en_nxt_i  (w_en_nxt[1]),
    .full_o    (w_full[1]),
    .data_o    (w_hold1)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      state_q <= ST_OFF;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (run_i) state_d = ST_FILL;
      ST_FILL: begin
        if (!run_i)
          state_d = ST_OFF;
        else if (w_all_full)
          state_d = ST_RUN;
      end
      ST_RUN:  if (w_done_rise && !run_i) state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    d_in_d     = d_in_q;
    enable_d   = enable_q;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;
    w_consume  = 2'b00;
    w_flush    = 2'b00;
    case (state_q)
      ST_OFF: begin
        d_in_d   = '0;
        enable_d = 1'b0;
        w_flush  = 2'b11;
        if (run_i)
          mode_d = mode_i;
      end
      ST_FILL: begin
        if (!run_i) begin
          w_flush = 2'b11;
        end else if (w_all_full) begin
          d_in_d    = pick_sample(mode_q, w_smp0, w_smp1);
          enable_d  = 1'b1;
          w_consume = w_sel_q;
        end
      end
      ST_RUN: begin
        if (w_done_rise) begin
          if (!run_i) begin
            d_in_d   = '0;
            enable_d = 1'b0;
            w_flush  = 2'b11;
          end else begin
            // New mode takes effect on this frame boundary.
            mode_d    = mode_i;
            w_flush   = ~w_sel_new;
            w_consume = w_sel_new & w_full;
            d_in_d    = pick_sample(mode_i, w_smp0, w_smp1);
            if (|w_missing) begin
              underrun_d = 1'b1;
              if (!(&ucnt_q))
                ucnt_d = ucnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        d_in_d   = '0;
        enable_d = 1'b0;
        w_flush  = 2'b11;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q     <= MODE_MUTE;
      done_q     <= 1'b0;
      d_in_q     <= '0;
      enable_q   <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      done_q     <= done_i;
      d_in_q     <= d_in_d;
      enable_q   <= enable_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign d_in_o         = d_in_q;
  assign enable_o       = enable_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt_q;

endmodule
`default_nettype wire
